// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - multi-key debouncer with internal sample tick and press/release pulses
// Keys are synchronized, then sampled once per tick by an independent 4-state FSM per key.
module key_debouncer #(
  parameter int N_KEYS       = 5,
  parameter int DIV_BITS     = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              tick
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [3:0] STAB_MAX = 4'(STABLE_TICKS);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;
  logic [N_KEYS-1:0]   sync1_q;
  logic [N_KEYS-1:0]   sync2_q;

  assign cnt_d = cnt_q + DIV_BITS'(1);
  assign tick  = &cnt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t     state_q, state_d;
    logic [3:0] stab_q, stab_d;
    logic [3:0] stab_inc;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       s;

    assign s        = sync2_q[i];
    assign stab_inc = stab_q + 4'd1;

    always_comb begin
      state_d   = state_q;
      stab_d    = stab_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (s) begin
              state_d = PRESS_CHK;
              stab_d  = 4'd1;
            end
          end
          PRESS_CHK: begin
            if (!s) begin
              state_d = IDLE;
              stab_d  = 4'd0;
            end else if (stab_inc == STAB_MAX) begin
              state_d = HELD;
              stab_d  = 4'd0;
              press_d = 1'b1;
            end else begin
              stab_d = stab_inc;
            end
          end
          HELD: begin
            if (!s) begin
              state_d = RELEASE_CHK;
              stab_d  = 4'd1;
            end
          end
          RELEASE_CHK: begin
            if (s) begin
              state_d = HELD;
              stab_d  = 4'd0;
            end else if (stab_inc == STAB_MAX) begin
              state_d   = IDLE;
              stab_d    = 4'd0;
              release_d = 1'b1;
            end else begin
              stab_d = stab_inc;
            end
          end
          default: begin
            state_d = IDLE;
            stab_d  = 4'd0;
          end
        endcase
      end
      // Level follows the next state so it moves on the same edge as the transition.
      level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
    end

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        state_q   <= IDLE;
        stab_q    <= 4'd0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        stab_q    <= stab_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed self-checking bench for key_debouncer
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] key_in = 2'b00;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_KEYS      (2),
    .DIV_BITS    (3),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .tick       (tick)
  );

  // Cycle index: cycle k is the interval after the k-th clk edge since reset release.
  always @(posedge clk or negedge clr) begin
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc cycle=%0d expected=%0d", cyc, c);
    end
  endtask

  task automatic do_reset(input logic [1:0] keys);
    key_in = keys;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_tick;
    key_in = 2'b11;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release, tick} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected %b", {key_level, key_press, key_release, tick}, 7'b0);
    end
    clr = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      wait_cyc(c);
      exp_tick = ((c % 8) == 7);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_tick cycle=%0d got %b expected %b", c, tick, exp_tick);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] exp;
    do_reset(2'b00);
    for (int c = 0; c <= 28; c++) begin
      wait_cyc(c);
      if (c == 2) key_in = 2'b01;
      exp = {(c >= 24) ? 2'b01 : 2'b00, (c == 24) ? 2'b01 : 2'b00, 2'b00};
      checks++;
      if ({key_level, key_press, key_release} !== exp) begin
        errors++;
        $display("FAIL clean_press cycle=%0d got %b expected %b", c, {key_level, key_press, key_release}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    do_reset(2'b00);
    for (int c = 0; c <= 44; c++) begin
      wait_cyc(c);
      if (c == 2)  key_in = 2'b01;
      if (c == 12) key_in = 2'b00;
      if (c == 20) key_in = 2'b01;
      exp = {(c >= 40) ? 2'b01 : 2'b00, (c == 40) ? 2'b01 : 2'b00, 2'b00};
      checks++;
      if ({key_level, key_press, key_release} !== exp) begin
        errors++;
        $display("FAIL bounce cycle=%0d got %b expected %b", c, {key_level, key_press, key_release}, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [5:0] exp;
    do_reset(2'b00);
    for (int c = 0; c <= 68; c++) begin
      wait_cyc(c);
      if (c == 2)  key_in = 2'b01;
      if (c == 26) key_in = 2'b00;
      if (c == 36) key_in = 2'b01;
      if (c == 39) key_in = 2'b00;
      exp = {(c >= 24 && c < 64) ? 2'b01 : 2'b00,
             (c == 24) ? 2'b01 : 2'b00,
             (c == 64) ? 2'b01 : 2'b00};
      checks++;
      if ({key_level, key_press, key_release} !== exp) begin
        errors++;
        $display("FAIL release cycle=%0d got %b expected %b", c, {key_level, key_press, key_release}, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    do_reset(2'b00);
    for (int c = 0; c <= 52; c++) begin
      wait_cyc(c);
      if (c == 2)  key_in = 2'b11;
      if (c == 26) key_in = 2'b01;
      exp = {(c < 24) ? 2'b00 : (c < 48) ? 2'b11 : 2'b01,
             (c == 24) ? 2'b11 : 2'b00,
             (c == 48) ? 2'b10 : 2'b00};
      checks++;
      if ({key_level, key_press, key_release} !== exp) begin
        errors++;
        $display("FAIL simultaneous cycle=%0d got %b expected %b", c, {key_level, key_press, key_release}, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] exp;
    do_reset(2'b00);
    for (int c = 0; c <= 18; c++) begin
      wait_cyc(c);
      if (c == 2) key_in = 2'b01;
    end
    clr = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, tick} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b expected %b", {key_level, key_press, key_release, tick}, 7'b0);
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c <= 31; c++) begin
      wait_cyc(c);
      exp = {(c >= 24) ? 2'b01 : 2'b00, (c == 24) ? 2'b01 : 2'b00, 2'b00};
      checks++;
      if ({key_level, key_press, key_release} !== exp) begin
        errors++;
        $display("FAIL mid_reset_restart cycle=%0d got %b expected %b", c, {key_level, key_press, key_release}, exp);
      end
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_before_async got %b expected 1", tick);
    end
    clr = 1'b0;
    #1;
    checks++;
    if ({key_level, tick} !== 3'b000) begin
      errors++;
      $display("FAIL async_clear got %b expected %b", {key_level, tick}, 3'b000);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
